// File: rtl/counter_tap_checker.sv
// Continuity monitor for a tapped free-running counter: checks each valid sample
// advanced by exactly one count, tracks lock and keeps a saturating error tally.
module counter_tap_checker #(
  parameter int LOW_W    = 8,
  parameter int HIGH_W   = 6,
  parameter int LOCK_N   = 4,
  parameter int ERRCNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [HIGH_W+LOW_W-1:0] tap_in,
  input  logic                    err_clr,
  output logic                    locked,
  output logic                    err_pulse,
  output logic [ERRCNT_W-1:0]     err_count,
  output logic [1:0]              state_dbg
);

  localparam int TAP_W = HIGH_W + LOW_W;
  localparam int CNT_W = (LOCK_N > 2) ? $clog2(LOCK_N) : 1;
  localparam logic [CNT_W-1:0]    LAST_GOOD = CNT_W'(LOCK_N - 1);
  localparam logic [ERRCNT_W-1:0] ERR_MAX   = '1;

  typedef enum logic [1:0] {
    UNSYNC  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TAP_W-1:0]  prev_q;
  logic [CNT_W-1:0]  good_cnt_q, good_cnt_d;
  logic              err_pulse_q, err_d;
  logic [ERRCNT_W-1:0] err_count_q;

  logic [LOW_W-1:0]  cur_low, prev_low, low_inc;
  logic [HIGH_W-1:0] cur_high, prev_high, high_inc;
  logic              low_wrap, is_good;

  assign cur_low   = tap_in[LOW_W-1:0];
  assign cur_high  = tap_in[TAP_W-1:LOW_W];
  assign prev_low  = prev_q[LOW_W-1:0];
  assign prev_high = prev_q[TAP_W-1:LOW_W];
  assign low_inc   = prev_low + LOW_W'(1);
  assign high_inc  = prev_high + HIGH_W'(1);
  assign low_wrap  = &prev_low;
  // The high field may only step when the low field rolls over.
  assign is_good   = (cur_low == low_inc) &&
                     ((cur_high == prev_high) || (low_wrap && (cur_high == high_inc)));

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_d      = 1'b0;
    if (in_valid) begin
      case (state_q)
        UNSYNC: begin
          state_d    = ACQUIRE;
          good_cnt_d = '0;
        end
        ACQUIRE: begin
          if (!is_good) begin
            good_cnt_d = '0;
          end else if (good_cnt_q == LAST_GOOD) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + CNT_W'(1);
          end
        end
        LOCKED: begin
          if (!is_good) begin
            state_d    = ACQUIRE;
            good_cnt_d = '0;
            err_d      = 1'b1;
          end
        end
        default: begin
          state_d    = UNSYNC;
          good_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= UNSYNC;
      prev_q      <= '0;
      good_cnt_q  <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      err_pulse_q <= err_d;
      if (in_valid) prev_q <= tap_in;
      // A clear coinciding with a new error leaves exactly that error counted.
      if (err_d) begin
        if (err_clr)                   err_count_q <= ERRCNT_W'(1);
        else if (err_count_q != ERR_MAX) err_count_q <= err_count_q + ERRCNT_W'(1);
      end else if (err_clr) begin
        err_count_q <= '0;
      end
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_counter_tap_checker.sv
// Bench for counter_tap_checker: directed vector table, saturation run on a
// narrow-counter instance, and a randomized stream against a reference model.
module tb_counter_tap_checker;

  localparam int LOW_W  = 8;
  localparam int HIGH_W = 6;
  localparam int TAP_W  = 14;
  localparam int LOCK_N = 4;
  localparam int ERR_W  = 16;
  localparam int S_LOCK = 2;
  localparam int S_ERRW = 4;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [TAP_W-1:0] tap_in;
  logic             err_clr;
  logic             locked, err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       state_dbg;
  logic             s_locked, s_err_pulse;
  logic [S_ERRW-1:0] s_err_count;
  logic [1:0]       s_state_dbg;

  int checks = 0;
  int errors = 0;

  counter_tap_checker #(.LOW_W(LOW_W), .HIGH_W(HIGH_W), .LOCK_N(LOCK_N), .ERRCNT_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .tap_in(tap_in), .err_clr(err_clr),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state_dbg(state_dbg)
  );

  counter_tap_checker #(.LOW_W(LOW_W), .HIGH_W(HIGH_W), .LOCK_N(S_LOCK), .ERRCNT_W(S_ERRW)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .tap_in(tap_in), .err_clr(err_clr),
    .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count), .state_dbg(s_state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integers describing lock status and error history.
  bit m_have, m_locked, m_pulse;
  int m_streak, m_prev, m_count;

  function automatic bit tap_good(int prev, int cur);
    int pl, ph, cl, ch;
    pl = prev % 256; ph = prev / 256;
    cl = cur % 256;  ch = cur / 256;
    return (((cl - pl + 256) % 256) == 1) &&
           ((ch == ph) || ((pl == 255) && (ch == (ph + 1) % 64)));
  endfunction

  task automatic model_step(input bit r, input bit v, input int tap, input bit clr);
    bit g;
    if (r) begin
      m_have = 0; m_locked = 0; m_pulse = 0; m_streak = 0; m_prev = 0; m_count = 0;
      return;
    end
    m_pulse = 0;
    if (v) begin
      if (!m_have) begin
        m_have = 1; m_streak = 0;
      end else begin
        g = tap_good(m_prev, tap);
        if (m_locked) begin
          if (!g) begin m_locked = 0; m_pulse = 1; m_streak = 0; end
        end else if (g) begin
          m_streak++;
          if (m_streak == LOCK_N) begin m_locked = 1; m_streak = 0; end
        end else begin
          m_streak = 0;
        end
      end
      m_prev = tap;
    end
    if (m_pulse) m_count = clr ? 1 : ((m_count == 65535) ? 65535 : m_count + 1);
    else if (clr) m_count = 0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic apply(input bit r, input bit v, input int tap, input bit clr);
    reset = r; in_valid = v; tap_in = TAP_W'(tap); err_clr = clr;
    @(posedge clk);
    #1;
    model_step(r, v, tap, clr);
  endtask

  typedef struct {
    bit rst;
    bit valid;
    bit clr;
    int tap;
    bit exp_locked;
    bit exp_pulse;
    int exp_count;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit v, input bit c, input int t,
                     input bit l, input bit p, input int n);
    vec_t x;
    x.rst = r; x.valid = v; x.clr = c; x.tap = t;
    x.exp_locked = l; x.exp_pulse = p; x.exp_count = n;
    vecs.push_back(x);
  endtask

  task automatic seq(input int first, input int n, input bit lock_last);
    for (int i = 0; i < n; i++)
      add(0, 1, 0, (first + i) % 16384, (lock_last && i == n - 1), 0, 0);
  endtask

  initial begin
    int t, n_err, exp_sat;
    reset = 1'b1; in_valid = 1'b0; tap_in = '0; err_clr = 1'b0;

    // Acquire from reset and lock after the fourth good step.
    add(1, 0, 0, 0, 0, 0, 0);
    seq('h0000, 5, 1);
    // Low wrap with high step, low wrap with high hold, high field wrap.
    add(1, 0, 0, 0, 0, 0, 0);
    seq('h00FA, 5, 1);
    add(0, 1, 0, 'h00FF, 1, 0, 0);
    add(0, 1, 0, 'h0100, 1, 0, 0);
    add(0, 1, 0, 'h0101, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    seq('h00FB, 5, 1);
    add(0, 1, 0, 'h0000, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    seq('h3FFB, 5, 1);
    add(0, 1, 0, 'h0000, 1, 0, 0);
    // Skip while locked, then relock.
    add(1, 0, 0, 0, 0, 0, 0);
    seq('h000C, 5, 1);
    add(0, 1, 0, 'h0012, 0, 1, 1);
    add(0, 1, 0, 'h0013, 0, 0, 1);
    add(0, 1, 0, 'h0014, 0, 0, 1);
    add(0, 1, 0, 'h0015, 0, 0, 1);
    add(0, 1, 0, 'h0016, 1, 0, 1);
    // High change without wrap; bad sample in ACQUIRE is not counted.
    add(1, 0, 0, 0, 0, 0, 0);
    seq('h004C, 5, 1);
    add(0, 1, 0, 'h0151, 0, 1, 1);
    add(0, 1, 0, 'h0153, 0, 0, 1);
    // Gaps in in_valid, then err_clr interaction.
    add(1, 0, 0, 0, 0, 0, 0);
    seq('h001C, 5, 1);
    add(0, 0, 0, 'h1234, 1, 0, 0);
    add(0, 0, 0, 'h0999, 1, 0, 0);
    add(0, 0, 0, 'h3FFF, 1, 0, 0);
    add(0, 1, 0, 'h0021, 1, 0, 0);
    add(0, 1, 0, 'h0030, 0, 1, 1);
    add(0, 1, 0, 'h0031, 0, 0, 1);
    add(0, 1, 0, 'h0032, 0, 0, 1);
    add(0, 1, 0, 'h0033, 0, 0, 1);
    add(0, 1, 0, 'h0034, 1, 0, 1);
    add(0, 1, 1, 'h0036, 0, 1, 1);
    add(0, 0, 1, 'h0000, 0, 0, 0);
    // Counter restarting at zero while locked, relock, then reset while locked.
    add(1, 0, 0, 0, 0, 0, 0);
    seq('h0000, 5, 1);
    add(0, 1, 0, 'h0000, 0, 1, 1);
    add(0, 1, 0, 'h0001, 0, 0, 1);
    add(0, 1, 0, 'h0002, 0, 0, 1);
    add(0, 1, 0, 'h0003, 0, 0, 1);
    add(0, 1, 0, 'h0004, 1, 0, 1);
    add(1, 1, 0, 'h0005, 0, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].valid, vecs[i].tap, vecs[i].clr);
      check($sformatf("vec%0d_locked", i), int'(locked), int'(vecs[i].exp_locked));
      check($sformatf("vec%0d_pulse", i), int'(err_pulse), int'(vecs[i].exp_pulse));
      check($sformatf("vec%0d_count", i), int'(err_count), vecs[i].exp_count);
    end

    // Saturation on the narrow instance: 2^4+2 errors, count must pin at 15.
    apply(1, 0, 0, 0);
    t = 'h0100;
    for (int i = 0; i <= S_LOCK; i++) begin
      apply(0, 1, t, 0);
      t++;
    end
    check("sat_locked_initial", int'(s_locked), 1);
    n_err = 0;
    for (int e = 0; e < (1 << S_ERRW) + 2; e++) begin
      t = (t + 2) % 16384;
      apply(0, 1, t, 0);
      n_err++;
      exp_sat = (n_err > 15) ? 15 : n_err;
      check("sat_pulse", int'(s_err_pulse), 1);
      check("sat_count", int'(s_err_count), exp_sat);
      for (int k = 0; k < S_LOCK; k++) begin
        t = (t + 1) % 16384;
        apply(0, 1, t, 0);
      end
      check("sat_relock", int'(s_locked), 1);
    end
    apply(1, 1, t + 1, 0);
    check("sat_reset_locked", int'(s_locked), 0);
    check("sat_reset_count", int'(s_err_count), 0);

    // Randomized stream of mostly-contiguous taps with jumps, gaps and clears.
    apply(1, 0, 0, 0);
    t = $urandom_range(0, 16383);
    for (int c = 0; c < 3000; c++) begin
      bit v, clr;
      int r;
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      r   = $urandom_range(0, 39);
      if (v) begin
        if (r == 0)      t = $urandom_range(0, 16383);
        else if (r == 1) t = (t + 2) % 16384;
        else if (r == 2) t = (t + 256) % 16384;
        else if (r == 3 && (t % 256) == 255) t = t - 255;
        else             t = (t + 1) % 16384;
      end
      apply(0, v, t, clr);
      check("rnd_locked", int'(locked), int'(m_locked));
      check("rnd_pulse", int'(err_pulse), int'(m_pulse));
      check("rnd_count", int'(err_count), m_count);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
